// File: rtl/riscv_core_fwd_ctrl_if.sv
// rtl/riscv_core_fwd_ctrl_if.sv - ID-stage operand/hazard bundle between pipeline and forwarding controller
// RISCV_CORE_FWD_STALL_CNT_EN adds the stall counter and its clear to the bundle.
interface riscv_core_fwd_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              i_id_valid;
  logic [REG_AW-1:0] i_id_rs1;
  logic [REG_AW-1:0] i_id_rs2;
  logic              i_id_use_rs1;
  logic              i_id_use_rs2;
  logic [REG_AW-1:0] i_id_rd;
  logic              i_id_regwrite;
  logic              i_id_memread;
  logic              i_mem_stall;
  logic              i_flush;
  logic [1:0]        o_fwd_a_sel;
  logic [1:0]        o_fwd_b_sel;
  logic              o_stall;
  logic              o_bubble;
`ifdef RISCV_CORE_FWD_STALL_CNT_EN
  logic              i_stall_cnt_clr;
  logic [31:0]       o_stall_cnt;
`endif

  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
           i_id_rd, i_id_regwrite, i_id_memread, i_mem_stall, i_flush,
`ifdef RISCV_CORE_FWD_STALL_CNT_EN
    output i_stall_cnt_clr,
    input  o_stall_cnt,
`endif
    input  o_fwd_a_sel, o_fwd_b_sel, o_stall, o_bubble
  );

  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
           i_id_rd, i_id_regwrite, i_id_memread, i_mem_stall, i_flush,
`ifdef RISCV_CORE_FWD_STALL_CNT_EN
    input  i_stall_cnt_clr,
    output o_stall_cnt,
`endif
    output o_fwd_a_sel, o_fwd_b_sel, o_stall, o_bubble
  );
endinterface

// File: rtl/riscv_core_fwd_ctrl.sv
// rtl/riscv_core_fwd_ctrl.sv - RV64I EX operand forwarding selects, load-use bubble, freeze and flush control
// Optional saturating stall-cycle counter under RISCV_CORE_FWD_STALL_CNT_EN.
module riscv_core_fwd_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  riscv_core_fwd_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_HOLD   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // MEM/WB is not tracked: its producer is covered by the write-first register file.
  logic              idex_valid_q, idex_valid_d;
  logic [REG_AW-1:0] idex_rd_q, idex_rd_d;
  logic              idex_regwrite_q, idex_regwrite_d;
  logic              idex_memread_q, idex_memread_d;
  logic              exmem_valid_q, exmem_valid_d;
  logic [REG_AW-1:0] exmem_rd_q, exmem_rd_d;
  logic              exmem_regwrite_q, exmem_regwrite_d;
  logic [1:0]        sel_a_q, sel_a_d;
  logic [1:0]        sel_b_q, sel_b_d;
  logic              pend_flush_q, pend_flush_d;

  logic advance, kill, load_use, stall, id_kill;
  logic idex_wr, exmem_wr;
  logic a_ex, a_mem, b_ex, b_mem;
  logic [1:0] sel_a_new, sel_b_new;

  assign advance  = !bus.i_mem_stall;
  assign kill     = bus.i_flush | pend_flush_q;

  assign idex_wr  = idex_valid_q & idex_regwrite_q & (idex_rd_q != '0);
  assign exmem_wr = exmem_valid_q & exmem_regwrite_q & (exmem_rd_q != '0);

  assign a_ex  = bus.i_id_use_rs1 & idex_wr  & (idex_rd_q  == bus.i_id_rs1);
  assign a_mem = bus.i_id_use_rs1 & exmem_wr & (exmem_rd_q == bus.i_id_rs1);
  assign b_ex  = bus.i_id_use_rs2 & idex_wr  & (idex_rd_q  == bus.i_id_rs2);
  assign b_mem = bus.i_id_use_rs2 & exmem_wr & (exmem_rd_q == bus.i_id_rs2);

  assign sel_a_new = a_ex ? 2'b10 : (a_mem ? 2'b01 : 2'b00);
  assign sel_b_new = b_ex ? 2'b10 : (b_mem ? 2'b01 : 2'b00);

  assign load_use = bus.i_id_valid & idex_memread_q & (a_ex | b_ex);
  // A flush on an advancing edge supersedes the load-use stall: the dependent op dies anyway.
  assign stall    = load_use & !(advance & kill);
  assign id_kill  = stall | kill | !bus.i_id_valid;

  assign bus.o_stall     = stall;
  assign bus.o_bubble    = advance & (stall | kill);
  assign bus.o_fwd_a_sel = sel_a_q;
  assign bus.o_fwd_b_sel = sel_b_q;

  always_comb begin
    idex_valid_d     = idex_valid_q;
    idex_rd_d        = idex_rd_q;
    idex_regwrite_d  = idex_regwrite_q;
    idex_memread_d   = idex_memread_q;
    exmem_valid_d    = exmem_valid_q;
    exmem_rd_d       = exmem_rd_q;
    exmem_regwrite_d = exmem_regwrite_q;
    sel_a_d          = sel_a_q;
    sel_b_d          = sel_b_q;
    pend_flush_d     = pend_flush_q | bus.i_flush;
    if (advance) begin
      pend_flush_d     = 1'b0;
      exmem_valid_d    = idex_valid_q;
      exmem_rd_d       = idex_rd_q;
      exmem_regwrite_d = idex_regwrite_q;
      if (id_kill) begin
        idex_valid_d    = 1'b0;
        idex_rd_d       = '0;
        idex_regwrite_d = 1'b0;
        idex_memread_d  = 1'b0;
        sel_a_d         = 2'b00;
        sel_b_d         = 2'b00;
      end else begin
        idex_valid_d    = 1'b1;
        idex_rd_d       = bus.i_id_rd;
        idex_regwrite_d = bus.i_id_regwrite;
        idex_memread_d  = bus.i_id_memread;
        sel_a_d         = sel_a_new;
        sel_b_d         = sel_b_new;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (!advance)   state_d = MEM_HOLD;
        else if (stall) state_d = LOAD_STALL;
      end
      LOAD_STALL: state_d = advance ? RUN : MEM_HOLD;
      MEM_HOLD:   state_d = advance ? RUN : MEM_HOLD;
      default:    state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q          <= RUN;
      idex_valid_q     <= 1'b0;
      idex_rd_q        <= '0;
      idex_regwrite_q  <= 1'b0;
      idex_memread_q   <= 1'b0;
      exmem_valid_q    <= 1'b0;
      exmem_rd_q       <= '0;
      exmem_regwrite_q <= 1'b0;
      sel_a_q          <= 2'b00;
      sel_b_q          <= 2'b00;
      pend_flush_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      idex_valid_q     <= idex_valid_d;
      idex_rd_q        <= idex_rd_d;
      idex_regwrite_q  <= idex_regwrite_d;
      idex_memread_q   <= idex_memread_d;
      exmem_valid_q    <= exmem_valid_d;
      exmem_rd_q       <= exmem_rd_d;
      exmem_regwrite_q <= exmem_regwrite_d;
      sel_a_q          <= sel_a_d;
      sel_b_q          <= sel_b_d;
      pend_flush_q     <= pend_flush_d;
    end
  end

`ifdef RISCV_CORE_FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.i_stall_cnt_clr)                 stall_cnt_d = '0;
    else if (stall && (stall_cnt_q != '1))   stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign bus.o_stall_cnt = stall_cnt_q;
`endif

endmodule
